fp_add_operand_stage: RTL and testbench
=======================================

Name: fp_add_operand_stage

Overview:
- Input stage of the single-precision FP adder/subtractor.
- Accepts two IEEE-754 binary32 operands and an add/sub opcode over a valid/ready handshake, unpacks and classifies each operand, and applies the subtract sign flip.
- Orders the operands by magnitude and computes alignment information.
- Two-stage registered pipeline with full backpressure. It feeds the special-case resolver (type/sign/exp/mantissa fields) and the alignment/add datapath (swapped significands, exponent difference).

Parameters:
- TYPE_W, 3, width of the operand class code. Codes: ZERO=000, INF=001, SUBNORMAL=010, NORMAL=011, NAN=100.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept the pair this cycle
- in_a  in  32  operand A, binary32
- in_b  in  32  operand B, binary32
- in_sub  in  1  1 = A-B, 0 = A+B
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts the bundle
- sign_A, sign_B  out  1 each  sign_B already flipped when in_sub=1
- exp_A, exp_B  out  8 each  raw biased exponents
- mantis_A, mantis_B  out  23 each  raw fraction fields
- type_A, type_B  out  3 each  class codes
- big_sign  out  1  sign of the larger-magnitude operand
- big_exp  out  8  effective exponent of the larger operand (subnormal -> 1)
- big_sig, small_sig  out  24 each  significands with hidden bit (1 for NORMAL, 0 otherwise)
- exp_diff  out  8  big effective exponent minus small effective exponent
- eff_sub  out  1  sign_A XOR sign_B (post-flip)

Behaviour:
- Classification:
  - exp==0, frac==0 -> ZERO
  - exp==0, frac!=0 -> SUBNORMAL
  - exp==FF, frac==0 -> INF
  - exp==FF, frac!=0 -> NAN
  - anything else -> NORMAL
- Stage 1 (S1) registers the unpacked fields, the post-flip signs and both types.
- Stage 2 (S2) registers the swap result:
  - A is "big" when {exp_A,mantis_A} >= {exp_B,mantis_B}, as an unsigned 31-bit compare. Ties choose A.
  - The compare ignores sign and class; NaN/INF values still produce a defined compare.
  - exp_diff is computed in 8 bits with no wrap, since big >= small by construction. Maximum 254 (FF vs 01).
  - Raw fields and types pass from S1 to S2 unchanged.
- Handshake:
  - Transfer occurs on valid&ready. Each stage holds valid_s1/valid_s2 flags.
  - S2 loads when (!valid_s2 || out_ready). S1 loads when (!valid_s1 || S2 loads).
  - in_ready equals the S1 load condition and is combinational from out_ready and the valid flags.
  - out_valid = valid_s2.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - Data registers update only on their stage's load. Valid flags clear when a stage is emptied without a refill.
- Latency and throughput:
  - Latency is 2 cycles, from the accepting edge to out_valid high.
  - Throughput is 1 pair/cycle with out_ready held high.
  - With out_ready low, at most 2 pairs are held. in_ready falls when both stages are full.
- Simultaneous events:
  - When S2 drains and S1 refills in the same cycle, no bubble is inserted and no data is lost or duplicated.
  - in_valid=1 while in_ready=0 is ignored; the source must hold its inputs stable.
- Reset, asynchronous and effective mid-operation:
  - valid_s1 and valid_s2 clear to 0 and all data registers clear to 0. Resulting outputs are out_valid=0, all fields 0, type_A=type_B=ZERO.
  - in_ready is 1 as soon as reset is released.
  - Pairs in flight are discarded.
- No arithmetic exceptions are raised here. NaN payloads, INF, and ZERO pass through for the downstream special-case resolver.

Test Plan:
- Reset then single pair: rst_n low mid-stream with 2 pairs in flight -> out_valid=0 and all outputs 0 immediately. After release, in_a=3F800000, in_b=40000000, in_sub=0 accepted -> 2 cycles later type_A=type_B=011, big_exp=80, big_sig=800000, small_sig=800000, exp_diff=1, big_sign=0, eff_sub=0.
- Subtract flip and tie: in_a=in_b=C0400000, in_sub=1 -> sign_A=1, sign_B=0, eff_sub=1, A chosen as big (big_sign=1), exp_diff=0.
- Classification sweep:
  - 00000000 -> type 000
  - 7F800000 -> 001
  - 00000001 -> 010, effective exp 1
  - 7FC00001 -> 100
  - 3F800000 -> 011
  - Subnormal 00000001 vs 00800000 -> exp_diff=0, big_sig=800000, small_sig=000001.
- Backpressure: stream 5 pairs with out_ready low for 4 cycles -> in_ready drops after 2 acceptances and outputs hold steady. On release, all 5 pairs emerge in order with none dropped or duplicated.
- Full throughput: out_ready=1 and in_valid=1 for 100 random pairs -> one output per cycle after 2-cycle fill, matching a reference model field-for-field.
- Extreme exponent gap: in_a=7F7FFFFF, in_b=00000001 -> exp_diff=FD, big is A. Swapped order (in_a=00000001, in_b=7F7FFFFF) -> big_sign taken from B, same exp_diff.

Source files
------------

// File: rtl/fp_add_operand_stage.sv
// Input stage of the binary32 adder/subtractor: unpacks and classifies both operands,
// applies the subtract sign flip, then orders them by magnitude and computes the alignment shift.
module fp_add_operand_stage #(
    parameter int TYPE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_A,
    output logic              sign_B,
    output logic [7:0]        exp_A,
    output logic [7:0]        exp_B,
    output logic [22:0]       mantis_A,
    output logic [22:0]       mantis_B,
    output logic [TYPE_W-1:0] type_A,
    output logic [TYPE_W-1:0] type_B,
    output logic              big_sign,
    output logic [7:0]        big_exp,
    output logic [23:0]       big_sig,
    output logic [23:0]       small_sig,
    output logic [7:0]        exp_diff,
    output logic              eff_sub
);

    localparam logic [TYPE_W-1:0] TYPE_ZERO = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_INF  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_SUB  = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_NORM = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] TYPE_NAN  = TYPE_W'(4);

    function automatic logic [TYPE_W-1:0] classify(input logic [7:0] e, input logic [22:0] f);
        logic [TYPE_W-1:0] t;
        if (e == 8'h00)
            t = (f == 23'd0) ? TYPE_ZERO : TYPE_SUB;
        else if (e == 8'hFF)
            t = (f == 23'd0) ? TYPE_INF : TYPE_NAN;
        else
            t = TYPE_NORM;
        return t;
    endfunction

    // Zero and subnormal operands both sit at exponent 1 for alignment purposes.
    function automatic logic [7:0] eff_exp(input logic [7:0] e);
        return (e == 8'h00) ? 8'h01 : e;
    endfunction

    function automatic logic [23:0] full_sig(input logic [TYPE_W-1:0] t, input logic [22:0] f);
        return {(t == TYPE_NORM), f};
    endfunction

    logic              vld_p1, vld_p2;
    logic              load_p1, load_p2;

    logic              sign_a_p1, sign_b_p1;
    logic [7:0]        exp_a_p1, exp_b_p1;
    logic [22:0]       man_a_p1, man_b_p1;
    logic [TYPE_W-1:0] type_a_p1, type_b_p1;

    logic              sign_a_p2, sign_b_p2;
    logic [7:0]        exp_a_p2, exp_b_p2;
    logic [22:0]       man_a_p2, man_b_p2;
    logic [TYPE_W-1:0] type_a_p2, type_b_p2;
    logic              big_sign_p2, eff_sub_p2;
    logic [7:0]        big_exp_p2, exp_diff_p2;
    logic [23:0]       big_sig_p2, small_sig_p2;

    logic              a_big;
    logic              big_sign_nxt;
    logic [7:0]        big_exp_nxt, small_exp_nxt;
    logic [23:0]       big_sig_nxt, small_sig_nxt;

    assign load_p2  = !vld_p2 || out_ready;
    assign load_p1  = !vld_p1 || load_p2;
    assign in_ready = load_p1;

    // Magnitude order on the raw 31-bit encoding; ties keep A as the big operand.
    assign a_big = {exp_a_p1, man_a_p1} >= {exp_b_p1, man_b_p1};

    always_comb begin
        big_sign_nxt  = sign_a_p1;
        big_exp_nxt   = eff_exp(exp_a_p1);
        small_exp_nxt = eff_exp(exp_b_p1);
        big_sig_nxt   = full_sig(type_a_p1, man_a_p1);
        small_sig_nxt = full_sig(type_b_p1, man_b_p1);
        if (!a_big) begin
            big_sign_nxt  = sign_b_p1;
            big_exp_nxt   = eff_exp(exp_b_p1);
            small_exp_nxt = eff_exp(exp_a_p1);
            big_sig_nxt   = full_sig(type_b_p1, man_b_p1);
            small_sig_nxt = full_sig(type_a_p1, man_a_p1);
        end
    end

    // ---- stage 1: unpack, classify, subtract flip ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sign_a_p1 <= 1'b0;
            sign_b_p1 <= 1'b0;
            exp_a_p1  <= 8'd0;
            exp_b_p1  <= 8'd0;
            man_a_p1  <= 23'd0;
            man_b_p1  <= 23'd0;
            type_a_p1 <= TYPE_ZERO;
            type_b_p1 <= TYPE_ZERO;
        end else if (load_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sign_a_p1 <= in_a[31];
                sign_b_p1 <= in_b[31] ^ in_sub;
                exp_a_p1  <= in_a[30:23];
                exp_b_p1  <= in_b[30:23];
                man_a_p1  <= in_a[22:0];
                man_b_p1  <= in_b[22:0];
                type_a_p1 <= classify(in_a[30:23], in_a[22:0]);
                type_b_p1 <= classify(in_b[30:23], in_b[22:0]);
            end
        end
    end

    // ---- stage 2: swap by magnitude, exponent difference ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2       <= 1'b0;
            sign_a_p2    <= 1'b0;
            sign_b_p2    <= 1'b0;
            exp_a_p2     <= 8'd0;
            exp_b_p2     <= 8'd0;
            man_a_p2     <= 23'd0;
            man_b_p2     <= 23'd0;
            type_a_p2    <= TYPE_ZERO;
            type_b_p2    <= TYPE_ZERO;
            big_sign_p2  <= 1'b0;
            big_exp_p2   <= 8'd0;
            big_sig_p2   <= 24'd0;
            small_sig_p2 <= 24'd0;
            exp_diff_p2  <= 8'd0;
            eff_sub_p2   <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sign_a_p2    <= sign_a_p1;
                sign_b_p2    <= sign_b_p1;
                exp_a_p2     <= exp_a_p1;
                exp_b_p2     <= exp_b_p1;
                man_a_p2     <= man_a_p1;
                man_b_p2     <= man_b_p1;
                type_a_p2    <= type_a_p1;
                type_b_p2    <= type_b_p1;
                big_sign_p2  <= big_sign_nxt;
                big_exp_p2   <= big_exp_nxt;
                big_sig_p2   <= big_sig_nxt;
                small_sig_p2 <= small_sig_nxt;
                exp_diff_p2  <= big_exp_nxt - small_exp_nxt;
                eff_sub_p2   <= sign_a_p1 ^ sign_b_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign sign_A    = sign_a_p2;
    assign sign_B    = sign_b_p2;
    assign exp_A     = exp_a_p2;
    assign exp_B     = exp_b_p2;
    assign mantis_A  = man_a_p2;
    assign mantis_B  = man_b_p2;
    assign type_A    = type_a_p2;
    assign type_B    = type_b_p2;
    assign big_sign  = big_sign_p2;
    assign big_exp   = big_exp_p2;
    assign big_sig   = big_sig_p2;
    assign small_sig = small_sig_p2;
    assign exp_diff  = exp_diff_p2;
    assign eff_sub   = eff_sub_p2;

endmodule

// File: tb/tb_fp_add_operand_stage.sv
// Directed and table-driven bench for fp_add_operand_stage: reset, classification,
// ordering, backpressure and full-rate streaming against a small reference model.
module tb_fp_add_operand_stage;

    typedef struct packed {
        logic        sign_a;
        logic        sign_b;
        logic [2:0]  type_a;
        logic [2:0]  type_b;
        logic        big_sign;
        logic [7:0]  big_exp;
        logic [23:0] big_sig;
        logic [23:0] small_sig;
        logic [7:0]  exp_diff;
        logic        eff_sub;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        exp_t        e;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic        sign_A, sign_B, big_sign, eff_sub;
    logic [7:0]  exp_A, exp_B, big_exp, exp_diff;
    logic [22:0] mantis_A, mantis_B;
    logic [2:0]  type_A, type_B;
    logic [23:0] big_sig, small_sig;

    int tests = 0;
    int fails = 0;

    fp_add_operand_stage #(.TYPE_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_A(sign_A), .sign_B(sign_B),
        .exp_A(exp_A), .exp_B(exp_B),
        .mantis_A(mantis_A), .mantis_B(mantis_B),
        .type_A(type_A), .type_B(type_B),
        .big_sign(big_sign), .big_exp(big_exp),
        .big_sig(big_sig), .small_sig(small_sig),
        .exp_diff(exp_diff), .eff_sub(eff_sub)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [2:0] cls(input logic [31:0] x);
        if (x[30:23] == 8'h00) return (x[22:0] == 0) ? 3'b000 : 3'b010;
        if (x[30:23] == 8'hFF) return (x[22:0] == 0) ? 3'b001 : 3'b100;
        return 3'b011;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t r;
        int ea, eb;
        logic [23:0] sa, sb;
        r.sign_a = a[31];
        r.sign_b = b[31] ^ sub;
        r.type_a = cls(a);
        r.type_b = cls(b);
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        sa = {(r.type_a == 3'b011), a[22:0]};
        sb = {(r.type_b == 3'b011), b[22:0]};
        if (a[30:0] >= b[30:0]) begin
            r.big_sign = r.sign_a; r.big_exp = 8'(ea);
            r.big_sig = sa; r.small_sig = sb; r.exp_diff = 8'(ea - eb);
        end else begin
            r.big_sign = r.sign_b; r.big_exp = 8'(eb);
            r.big_sig = sb; r.small_sig = sa; r.exp_diff = 8'(eb - ea);
        end
        r.eff_sub = r.sign_a ^ r.sign_b;
        return r;
    endfunction

    task automatic check_out(input string tag, input exp_t e, input logic [31:0] a, input logic [31:0] b);
        check({tag, ".sign_A"},    32'(sign_A),    32'(e.sign_a));
        check({tag, ".sign_B"},    32'(sign_B),    32'(e.sign_b));
        check({tag, ".exp_A"},     32'(exp_A),     32'(a[30:23]));
        check({tag, ".exp_B"},     32'(exp_B),     32'(b[30:23]));
        check({tag, ".mantis_A"},  32'(mantis_A),  32'(a[22:0]));
        check({tag, ".mantis_B"},  32'(mantis_B),  32'(b[22:0]));
        check({tag, ".type_A"},    32'(type_A),    32'(e.type_a));
        check({tag, ".type_B"},    32'(type_B),    32'(e.type_b));
        check({tag, ".big_sign"},  32'(big_sign),  32'(e.big_sign));
        check({tag, ".big_exp"},   32'(big_exp),   32'(e.big_exp));
        check({tag, ".big_sig"},   32'(big_sig),   32'(e.big_sig));
        check({tag, ".small_sig"}, 32'(small_sig), 32'(e.small_sig));
        check({tag, ".exp_diff"},  32'(exp_diff),  32'(e.exp_diff));
        check({tag, ".eff_sub"},   32'(eff_sub),   32'(e.eff_sub));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 0);
        check({tag, ".zero"}, {31'd0, |{sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B, type_A,
              type_B, big_sign, big_exp, big_sig, small_sig, exp_diff, eff_sub}}, 0);
    endtask

    vec_t  vt[10];
    pair_t bp[5];
    pair_t rp[100];

    initial begin
        vt[0] = '{32'h3F800000, 32'h40000000, 1'b0, '{1'b0, 1'b0, 3'b011, 3'b011, 1'b0, 8'h80, 24'h800000, 24'h800000, 8'h01, 1'b0}};
        vt[1] = '{32'hC0400000, 32'hC0400000, 1'b1, '{1'b1, 1'b0, 3'b011, 3'b011, 1'b1, 8'h80, 24'hC00000, 24'hC00000, 8'h00, 1'b1}};
        vt[2] = '{32'h00000000, 32'h7F800000, 1'b0, '{1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 8'hFF, 24'h000000, 24'h000000, 8'hFE, 1'b0}};
        vt[3] = '{32'h00000001, 32'h7FC00001, 1'b0, '{1'b0, 1'b0, 3'b010, 3'b100, 1'b0, 8'hFF, 24'h400001, 24'h000001, 8'hFE, 1'b0}};
        vt[4] = '{32'h3F800000, 32'h3F800000, 1'b0, '{1'b0, 1'b0, 3'b011, 3'b011, 1'b0, 8'h7F, 24'h800000, 24'h800000, 8'h00, 1'b0}};
        vt[5] = '{32'h00000001, 32'h00800000, 1'b0, '{1'b0, 1'b0, 3'b010, 3'b011, 1'b0, 8'h01, 24'h800000, 24'h000001, 8'h00, 1'b0}};
        vt[6] = '{32'h7F7FFFFF, 32'h00000001, 1'b0, '{1'b0, 1'b0, 3'b011, 3'b010, 1'b0, 8'hFE, 24'hFFFFFF, 24'h000001, 8'hFD, 1'b0}};
        vt[7] = '{32'h00000001, 32'h7F7FFFFF, 1'b1, '{1'b0, 1'b1, 3'b010, 3'b011, 1'b1, 8'hFE, 24'hFFFFFF, 24'h000001, 8'hFD, 1'b1}};
        vt[8] = '{32'h3F800000, 32'h80000000, 1'b0, '{1'b0, 1'b1, 3'b011, 3'b000, 1'b0, 8'h7F, 24'h800000, 24'h000000, 8'h7E, 1'b1}};
        vt[9] = '{32'hFF800000, 32'h7F800001, 1'b1, '{1'b1, 1'b1, 3'b001, 3'b100, 1'b1, 8'hFF, 24'h000001, 24'h000000, 8'h00, 1'b0}};

        for (int i = 0; i < 5; i++)
            bp[i] = '{32'h3F800000 + 32'(i) * 32'h00100003, 32'h40000000 - 32'(i), 1'(i % 2)};
        for (int i = 0; i < 100; i++) begin
            rp[i].a = $urandom;
            rp[i].b = $urandom;
            rp[i].sub = 1'($urandom_range(0, 1));
            if (i % 7 == 0) rp[i].a[30:23] = 8'hFF;
            if (i % 5 == 0) rp[i].b[30:23] = 8'h00;
            if (i % 11 == 0) rp[i].b = rp[i].a;
        end

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        #1;
        check("reset_release.in_ready", 32'(in_ready), 1);

        // Two pairs in flight, then asynchronous reset mid-cycle
        @(negedge clk); in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        @(negedge clk); in_a = 32'hC0400000; in_b = 32'h41000000;
        @(negedge clk); in_valid = 1'b0;
        #1;
        check("inflight.out_valid", 32'(out_valid), 1);
        check("inflight.in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("post_reset.in_ready", 32'(in_ready), 1);

        // Single pair latency
        @(negedge clk); in_valid = 1'b1; in_a = vt[0].a; in_b = vt[0].b; in_sub = vt[0].sub;
        @(negedge clk); in_valid = 1'b0;
        #1;
        check("latency.cycle1", 32'(out_valid), 0);
        @(negedge clk);
        #1;
        check("latency.cycle2", 32'(out_valid), 1);
        check_out("single", vt[0].e, vt[0].a, vt[0].b);

        // Table of directed vectors
        for (int i = 0; i < 10; i++) begin
            int n;
            @(negedge clk);
            in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; in_sub = vt[i].sub;
            @(negedge clk); in_valid = 1'b0;
            n = 0;
            #1;
            while (!out_valid && n < 6) begin
                @(negedge clk); #1; n++;
            end
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 1);
            check_out($sformatf("vec%0d", i), vt[i].e, vt[i].a, vt[i].b);
        end
        @(negedge clk);

        // Backpressure: 5 pairs, out_ready low for the first 4 cycles
        begin
            int acc, got;
            acc = 0; got = 0;
            for (int c = 0; c < 40 && got < 5; c++) begin
                @(negedge clk);
                out_ready = (c >= 4);
                in_valid = (acc < 5);
                if (acc < 5) begin
                    in_a = bp[acc].a; in_b = bp[acc].b; in_sub = bp[acc].sub;
                end
                #1;
                if (c == 3) begin
                    check("bp.accepted", 32'(acc), 2);
                    check("bp.in_ready", 32'(in_ready), 0);
                    check("bp.hold_valid", 32'(out_valid), 1);
                    check("bp.hold_mantis_A", 32'(mantis_A), 32'(bp[0].a[22:0]));
                    check("bp.hold_big_sig", 32'(big_sig), 32'(model(bp[0].a, bp[0].b, bp[0].sub).big_sig));
                end
                if (out_valid && out_ready) begin
                    check_out($sformatf("bp%0d", got), model(bp[got].a, bp[got].b, bp[got].sub),
                              bp[got].a, bp[got].b);
                    got++;
                end
                if (in_valid && in_ready) acc++;
            end
            check("bp.count", 32'(got), 5);
            @(negedge clk); in_valid = 1'b0;
            #1;
            check("bp.drained", 32'(out_valid), 0);
        end

        // Full throughput with random operands
        begin
            int acc, got, bubbles;
            acc = 0; got = 0; bubbles = 0;
            out_ready = 1'b1;
            for (int c = 0; c < 200 && got < 100; c++) begin
                @(negedge clk);
                in_valid = (acc < 100);
                if (acc < 100) begin
                    in_a = rp[acc].a; in_b = rp[acc].b; in_sub = rp[acc].sub;
                end
                #1;
                if (got > 0 && !out_valid) bubbles++;
                if (out_valid && out_ready) begin
                    if (got == 0) check("stream.first_at_cycle", 32'(c), 2);
                    check_out($sformatf("rnd%0d", got), model(rp[got].a, rp[got].b, rp[got].sub),
                              rp[got].a, rp[got].b);
                    got++;
                end
                if (in_valid && in_ready) acc++;
            end
            check("stream.count", 32'(got), 100);
            check("stream.bubbles", 32'(bubbles), 0);
            in_valid = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
